clint_multi_hart: RTL and testbench

- Parametrised core-local interruptor serving HART_NUM harts from one shared 64-bit mtime.
- Adds a tick prescaler, a debug halt and registered read/interrupt outputs.
- Per hart: one msip register and one 64-bit mtimecmp register.
- Sits on the peripheral bus beside the bus arbiter and drives the interrupt-interface request lines of every hart.

---
 rtl/clint_multi_hart.sv | 150 +++++++++++++++
 tb/tb_clint_multi_hart.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_multi_hart.sv
// Core-local interruptor: shared prescaled 64-bit mtime, per-hart msip and mtimecmp,
// registered bus read data and registered timer interrupts.
module clint_multi_hart #(
    parameter int HART_NUM   = 1,
    parameter int TICK_DIV   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bus_clint_read_addr,
    input  logic [ADDR_WIDTH-1:0] bus_clint_write_addr,
    input  logic [1:0]            bus_clint_read_size,
    input  logic [1:0]            bus_clint_write_size,
    input  logic [DATA_WIDTH-1:0] bus_clint_data,
    input  logic                  bus_clint_rd,
    input  logic                  bus_clint_wr,
    output logic [DATA_WIDTH-1:0] clint_bus_data,
    input  logic                  dbg_halt,
    output logic [HART_NUM-1:0]   all_intif_int_software_req,
    output logic [HART_NUM-1:0]   all_intif_int_timer_req
);

    localparam logic [1:0]            SIZE_WORD     = 2'b10;
    localparam int                    MTIMECMP_BASE = 'h4000;
    localparam logic [ADDR_WIDTH-1:0] MTIME_LO_ADDR = ADDR_WIDTH'('hbff8);
    localparam logic [ADDR_WIDTH-1:0] MTIME_HI_ADDR = ADDR_WIDTH'('hbffc);
    localparam logic [15:0]           TICK_LAST     = 16'(TICK_DIV - 1);

    function automatic logic [ADDR_WIDTH-1:0] msip_addr(input int h);
        return ADDR_WIDTH'(4 * h);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] cmp_addr(input int h, input int half);
        return ADDR_WIDTH'(MTIMECMP_BASE + 8 * h + 4 * half);
    endfunction

    logic [15:0]           pre_cnt;
    logic                  tick;
    logic [63:0]           mtime;
    logic [HART_NUM-1:0]   msip;
    logic [63:0]           mtimecmp [HART_NUM];
    logic [HART_NUM-1:0]   timer_hit;
    logic [HART_NUM-1:0]   timer_req;

    logic                  wr_word;
    logic                  rd_word;
    logic [HART_NUM-1:0]   wr_msip;
    logic [HART_NUM-1:0]   wr_cmp_lo;
    logic [HART_NUM-1:0]   wr_cmp_hi;
    logic                  wr_mtime_lo;
    logic                  wr_mtime_hi;
    logic [DATA_WIDTH-1:0] rd_value;

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        wr_word     = bus_clint_wr && (bus_clint_write_size == SIZE_WORD);
        wr_msip     = '0;
        wr_cmp_lo   = '0;
        wr_cmp_hi   = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            wr_msip[h]   = wr_word && (bus_clint_write_addr == msip_addr(h));
            wr_cmp_lo[h] = wr_word && (bus_clint_write_addr == cmp_addr(h, 0));
            wr_cmp_hi[h] = wr_word && (bus_clint_write_addr == cmp_addr(h, 1));
        end
        wr_mtime_lo = wr_word && (bus_clint_write_addr == MTIME_LO_ADDR);
        wr_mtime_hi = wr_word && (bus_clint_write_addr == MTIME_HI_ADDR);
    end

    always_comb begin
        rd_word  = (bus_clint_read_size == SIZE_WORD);
        rd_value = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            if (bus_clint_read_addr == msip_addr(h))
                rd_value = DATA_WIDTH'(msip[h]);
            if (bus_clint_read_addr == cmp_addr(h, 0))
                rd_value = mtimecmp[h][31:0];
            if (bus_clint_read_addr == cmp_addr(h, 1))
                rd_value = mtimecmp[h][63:32];
        end
        if (bus_clint_read_addr == MTIME_LO_ADDR)
            rd_value = mtime[31:0];
        if (bus_clint_read_addr == MTIME_HI_ADDR)
            rd_value = mtime[63:32];
    end

    assign tick = !dbg_halt && (pre_cnt == TICK_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pre_cnt <= '0;
        else if (!dbg_halt)
            pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end

    // A bus write to mtime wins over a coincident tick; the prescaler keeps its phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mtime <= '0;
        else if (wr_mtime_lo)
            mtime[31:0] <= bus_clint_data;
        else if (wr_mtime_hi)
            mtime[63:32] <= bus_clint_data;
        else if (tick)
            mtime <= mtime + 64'd1;
    end

    // NOTE: the per-hart arrays are real registers with a defined reset value, not RAM, so they are reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msip <= '0;
            for (int h = 0; h < HART_NUM; h++)
                mtimecmp[h] <= '1;
        end else begin
            for (int h = 0; h < HART_NUM; h++) begin
                if (wr_msip[h])
                    msip[h] <= bus_clint_data[0];
                if (wr_cmp_lo[h])
                    mtimecmp[h][31:0] <= bus_clint_data;
                if (wr_cmp_hi[h])
                    mtimecmp[h][63:32] <= bus_clint_data;
            end
        end
    end

    always_comb begin
        timer_hit = '0;
        for (int h = 0; h < HART_NUM; h++)
            timer_hit[h] = (mtime >= mtimecmp[h]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timer_req <= '0;
        else
            timer_req <= timer_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clint_bus_data <= '0;
        else if (bus_clint_rd)
            clint_bus_data <= rd_word ? rd_value : '0;
    end

    assign all_intif_int_software_req = msip;
    assign all_intif_int_timer_req    = timer_req;

endmodule

// File: tb/tb_clint_multi_hart.sv
// Bench for clint_multi_hart: two instances (TICK_DIV 1 and 4, four harts) share one bus
// and are checked against directed expectations and a behavioural model.
module tb_clint_multi_hart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] raddr, waddr, wdata;
    logic [1:0]  rsize, wsize;
    logic        rd, wr, halt;
    logic [31:0] rdata1, rdata4;
    logic [3:0]  sw1, sw4, tm1, tm4;

    int n_cmp = 0;
    int n_err = 0;

    clint_multi_hart #(.HART_NUM(4), .TICK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst),
        .bus_clint_read_addr(raddr), .bus_clint_write_addr(waddr),
        .bus_clint_read_size(rsize), .bus_clint_write_size(wsize),
        .bus_clint_data(wdata), .bus_clint_rd(rd), .bus_clint_wr(wr),
        .clint_bus_data(rdata1), .dbg_halt(halt),
        .all_intif_int_software_req(sw1), .all_intif_int_timer_req(tm1)
    );

    clint_multi_hart #(.HART_NUM(4), .TICK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst),
        .bus_clint_read_addr(raddr), .bus_clint_write_addr(waddr),
        .bus_clint_read_size(rsize), .bus_clint_write_size(wsize),
        .bus_clint_data(wdata), .bus_clint_rd(rd), .bus_clint_wr(wr),
        .clint_bus_data(rdata4), .dbg_halt(halt),
        .all_intif_int_software_req(sw4), .all_intif_int_timer_req(tm4)
    );

    // Reference model, index 0 = TICK_DIV 1, index 1 = TICK_DIV 4.
    logic [63:0] m_mtime [2];
    int          m_pre   [2];
    logic [3:0]  m_msip  [2];
    logic [63:0] m_cmp   [2][4];
    logic [31:0] m_rdata [2];
    logic [3:0]  m_timer [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [31:0] a);
        logic [31:0] off;
        if (a < 32'h10 && a[1:0] == 2'b00)
            return {31'b0, m_msip[i][a[3:2]]};
        if (a >= 32'h4000 && a < 32'h4020 && a[1:0] == 2'b00) begin
            off = a - 32'h4000;
            return off[2] ? m_cmp[i][off[4:3]][63:32] : m_cmp[i][off[4:3]][31:0];
        end
        if (a == 32'hbff8) return m_mtime[i][31:0];
        if (a == 32'hbffc) return m_mtime[i][63:32];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mtime[i] = 64'h0;
            m_pre[i]   = 0;
            m_msip[i]  = 4'h0;
            m_rdata[i] = 32'h0;
            m_timer[i] = 4'h0;
            for (int h = 0; h < 4; h++) m_cmp[i][h] = '1;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit          tick;
            bit          hit_mtime;
            logic [31:0] off;
            if (rd) m_rdata[i] = (rsize == 2'b10) ? model_read(i, raddr) : 32'h0;
            for (int h = 0; h < 4; h++) m_timer[i][h] = (m_mtime[i] >= m_cmp[i][h]);
            tick = !halt && (m_pre[i] == div_of(i) - 1);
            if (!halt) m_pre[i] = tick ? 0 : m_pre[i] + 1;
            hit_mtime = 1'b0;
            if (wr && wsize == 2'b10) begin
                if (waddr < 32'h10 && waddr[1:0] == 2'b00)
                    m_msip[i][waddr[3:2]] = wdata[0];
                else if (waddr >= 32'h4000 && waddr < 32'h4020 && waddr[1:0] == 2'b00) begin
                    off = waddr - 32'h4000;
                    if (off[2]) m_cmp[i][off[4:3]][63:32] = wdata;
                    else        m_cmp[i][off[4:3]][31:0]  = wdata;
                end else if (waddr == 32'hbff8) begin
                    m_mtime[i][31:0] = wdata;
                    hit_mtime = 1'b1;
                end else if (waddr == 32'hbffc) begin
                    m_mtime[i][63:32] = wdata;
                    hit_mtime = 1'b1;
                end
            end
            if (tick && !hit_mtime) m_mtime[i] = m_mtime[i] + 64'd1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("div1 read data", rdata1, m_rdata[0]);
        check("div1 software_req", sw1, m_msip[0]);
        check("div1 timer_req", tm1, m_timer[0]);
        check("div4 read data", rdata4, m_rdata[1]);
        check("div4 software_req", sw4, m_msip[1]);
        check("div4 timer_req", tm4, m_timer[1]);
    endtask

    // One clock edge: advance the model with the inputs held across the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) model_update();
        else     model_reset();
        #1;
        compare_model();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; waddr = a; wdata = d; wsize = 2'b10; rd = 1'b0;
        step();
        wr = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  wsize;
        logic        rd;
        logic [31:0] raddr;
        logic [1:0]  rsize;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_sw;
    } vec_t;

    vec_t        tbl [11];
    logic [31:0] alist [16];
    int          act;

    initial begin
        tbl[0]  = '{1'b1, 32'hc,    32'h1,        2'b10, 1'b1, 32'hc,    2'b10, 32'h0,        4'b1000};
        tbl[1]  = '{1'b1, 32'hc,    32'hfffffffe, 2'b10, 1'b1, 32'hc,    2'b10, 32'h1,        4'b0000};
        tbl[2]  = '{1'b1, 32'h10,   32'h1,        2'b10, 1'b1, 32'h10,   2'b10, 32'h0,        4'b0000};
        tbl[3]  = '{1'b1, 32'h0,    32'h1,        2'b00, 1'b1, 32'h0,    2'b10, 32'h0,        4'b0000};
        tbl[4]  = '{1'b1, 32'h0,    32'h1,        2'b10, 1'b1, 32'h4008, 2'b10, 32'hffffffff, 4'b0001};
        tbl[5]  = '{1'b1, 32'h4008, 32'd20,       2'b10, 1'b1, 32'h0,    2'b00, 32'h0,        4'b0001};
        tbl[6]  = '{1'b1, 32'h400c, 32'h0,        2'b10, 1'b1, 32'h4008, 2'b10, 32'd20,       4'b0001};
        tbl[7]  = '{1'b0, 32'h0,    32'h0,        2'b10, 1'b1, 32'h400c, 2'b10, 32'h0,        4'b0001};
        tbl[8]  = '{1'b0, 32'h0,    32'h0,        2'b10, 1'b1, 32'h0,    2'b10, 32'h1,        4'b0001};
        tbl[9]  = '{1'b0, 32'h0,    32'h0,        2'b10, 1'b0, 32'h0,    2'b10, 32'h1,        4'b0001};
        tbl[10] = '{1'b1, 32'h4,    32'h1,        2'b10, 1'b1, 32'h4,    2'b10, 32'h0,        4'b0011};

        alist = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h4000, 32'h4004, 32'h4008,
                  32'h400c, 32'h4010, 32'h4018, 32'h401c, 32'h4020, 32'hbff8, 32'hbffc, 32'h4002};

        rst = 1'b0; rd = 1'b0; wr = 1'b0; halt = 1'b0;
        raddr = 32'h0; waddr = 32'h0; wdata = 32'h0; rsize = 2'b10; wsize = 2'b10;
        model_reset();
        step();
        step();
        check("reset read data", rdata1, 32'h0);
        check("reset software_req", sw1, 4'h0);
        check("reset timer_req", tm4, 4'h0);

        // Ten free-running cycles after reset release, then read mtime.
        rst = 1'b1;
        act = 0;
        repeat (10) begin
            step();
            act++;
        end
        rd = 1'b1; raddr = 32'hbff8; rsize = 2'b10;
        step();
        check("mtime after 10 cycles is 9 or 10", (rdata1 == 32'd9 || rdata1 == 32'd10), 1'b1);
        check("timer idle after reset", tm1, 4'h0);
        check("div4 mtime after reset run", rdata4, 32'(act / 4));
        act++;

        // Prescaler and debug halt: halt begins mid-phase and must resume from that phase.
        for (int e = 0; e < 40; e++) begin
            halt = (e >= 6 && e < 18);
            step();
            check("div1 mtime vs active cycles", rdata1, 32'(act));
            check("div4 mtime vs active cycles", rdata4, 32'(act / 4));
            if (!halt) act++;
        end
        halt = 1'b0; rd = 1'b0;

        // Software interrupts, mtimecmp access, illegal sizes, read-before-write.
        for (int v = 0; v < 11; v++) begin
            wr = tbl[v].wr; waddr = tbl[v].waddr; wdata = tbl[v].wdata; wsize = tbl[v].wsize;
            rd = tbl[v].rd; raddr = tbl[v].raddr; rsize = tbl[v].rsize;
            step();
            check($sformatf("table %0d div1 read", v), rdata1, tbl[v].exp_rdata);
            check($sformatf("table %0d div4 read", v), rdata4, tbl[v].exp_rdata);
            check($sformatf("table %0d div1 sw", v), sw1, tbl[v].exp_sw);
            check($sformatf("table %0d div4 sw", v), sw4, tbl[v].exp_sw);
        end
        wr = 1'b0; rd = 1'b0; rsize = 2'b10;

        // Timer compare on hart 1 (mtimecmp = 20): asserts one cycle after mtime reaches 20.
        halt = 1'b1;
        bus_write(32'hbff8, 32'h0);
        bus_write(32'hbffc, 32'h0);
        step();
        check("timer clear after mtime reload", tm1, 4'h0);
        halt = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            step();
            check($sformatf("hart1 timer edge %0d", j), tm1[1], (j >= 21));
            check($sformatf("hart0 timer edge %0d", j), tm1[0], 1'b0);
        end

        // Write on a tick cycle wins; the increment is lost.
        bus_write(32'hbff8, 32'd100);
        rd = 1'b1; raddr = 32'hbff8;
        step();
        check("write wins over tick", rdata1, 32'd100);
        rd = 1'b0;

        // mtime wrap with hart 2 compare at 1.
        halt = 1'b1;
        bus_write(32'hbffc, 32'hffffffff);
        bus_write(32'hbff8, 32'hffffffff);
        bus_write(32'h4010, 32'h1);
        bus_write(32'h4014, 32'h0);
        step();
        check("timers at mtime max", tm1, 4'b1111);
        halt = 1'b0;
        step();
        rd = 1'b1; raddr = 32'hbff8;
        step();
        check("mtime low after wrap", rdata1, 32'h0);
        check("timers after wrap", tm1, 4'b0000);
        raddr = 32'hbffc;
        step();
        check("mtime high after wrap", rdata1, 32'h0);
        rd = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr    = 1'($urandom);
            waddr = alist[$urandom % 16];
            wdata = ($urandom % 2 != 0) ? $urandom : ($urandom % 64);
            wsize = ($urandom % 4 == 0) ? 2'($urandom) : 2'b10;
            rd    = 1'($urandom);
            raddr = alist[$urandom % 16];
            rsize = ($urandom % 4 == 0) ? 2'($urandom) : 2'b10;
            halt  = ($urandom % 8 == 0);
            step();
        end
        wr = 1'b0; rd = 1'b0; halt = 1'b0; rsize = 2'b10; wsize = 2'b10;

        // Reset in the middle of operation clears everything at once.
        bus_write(32'h0, 32'h1);
        rd = 1'b1; raddr = 32'h4000;
        step();
        rst = 1'b0;
        #1;
        check("mid reset div1 read", rdata1, 32'h0);
        check("mid reset div1 sw", sw1, 4'h0);
        check("mid reset div1 timer", tm1, 4'h0);
        check("mid reset div4 read", rdata4, 32'h0);
        check("mid reset div4 sw", sw4, 4'h0);
        check("mid reset div4 timer", tm4, 4'h0);
        model_reset();
        rd = 1'b0;
        step();
        step();
        rst = 1'b1;
        rd = 1'b1; raddr = 32'hbff8;
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
